// File: rtl/ttl_irq_sync_edge.sv
// Three-flop synchroniser for one active-low request line with a falling-edge pulse.
// Flops restart at 1 on Clear so a level held low across reset is re-detected.
module ttl_irq_sync_edge (
    input  logic Clk,
    input  logic Clear,
    input  logic IR_bar,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge Clk) begin
        if (Clear) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= IR_bar;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign fall = s3 & ~s2;

endmodule

// File: rtl/ttl_irq_request_latch.sv
// Interrupt-request latch feeding an 8-to-3 priority encoder: synchronised edge capture,
// per-line mask, sticky overrun, and acknowledge by the encoder's active-low code.
module ttl_irq_request_latch #(
    parameter int unsigned WIDTH_IN   = 8,
    parameter int unsigned WIDTH_OUT  = 3,
    parameter int          DELAY_RISE = 0,
    parameter int          DELAY_FALL = 0
) (
    input  logic                 Clk,
    input  logic                 Clear,
    input  logic [WIDTH_IN-1:0]  IR_bar,
    input  logic                 Mask_load,
    input  logic [WIDTH_IN-1:0]  Mask_data,
    input  logic                 Ack,
    input  logic [WIDTH_OUT-1:0] Ack_code_bar,
    output logic [WIDTH_IN-1:0]  Req_bar,
    output logic                 Int,
    output logic [WIDTH_IN-1:0]  Mask,
    output logic [WIDTH_IN-1:0]  Overrun
);

    localparam bit PARAMS_OK = (WIDTH_IN == (2 ** WIDTH_OUT)) &&
                               (DELAY_RISE >= 0) && (DELAY_FALL >= 0);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("ttl_irq_request_latch: WIDTH_IN must equal 2**WIDTH_OUT and delays be >= 0");
        end
    endgenerate

    logic [WIDTH_IN-1:0]  fall;
    logic [WIDTH_IN-1:0]  ack_hit;
    logic [WIDTH_IN-1:0]  visible;
    logic [WIDTH_IN-1:0]  pending_q;
    logic [WIDTH_IN-1:0]  mask_q;
    logic [WIDTH_IN-1:0]  overrun_q;
    logic [WIDTH_OUT-1:0] ack_idx;

    genvar g;
    generate
        for (g = 0; g < WIDTH_IN; g++) begin : g_line
            ttl_irq_sync_edge u_sync (
                .Clk    (Clk),
                .Clear  (Clear),
                .IR_bar (IR_bar[g]),
                .fall   (fall[g])
            );
        end
    endgenerate

    assign ack_idx = ~Ack_code_bar;

    always_comb begin
        ack_hit = '0;
        if (Ack) begin
            ack_hit[ack_idx] = 1'b1;
        end
    end

    // A new edge wins over a coincident ack of the same line and is not an overrun.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            pending_q <= '0;
            mask_q    <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= (pending_q & ~ack_hit) | fall;
            overrun_q <= overrun_q | (fall & pending_q & ~ack_hit);
            if (Mask_load) begin
                mask_q <= Mask_data;
            end
        end
    end

    assign visible = pending_q & ~mask_q;
    assign Req_bar = ~visible;
    assign Int     = |visible;
    assign Mask    = mask_q;
    assign Overrun = overrun_q;

endmodule

// File: tb/tb_ttl_irq_request_latch.sv
// Directed scoreboard bench for ttl_irq_request_latch: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_ttl_irq_request_latch;

    logic       Clk;
    logic       Clear;
    logic [7:0] IR_bar;
    logic       Mask_load;
    logic [7:0] Mask_data;
    logic       Ack;
    logic [2:0] Ack_code_bar;
    logic [7:0] req_bar;
    logic       irq;
    logic [7:0] mask;
    logic [7:0] overrun;

    typedef struct {
        string      nm;
        int         due;
        logic [7:0] rb;
        logic       irq;
        logic [7:0] m;
        logic [7:0] ov;
    } exp_t;

    exp_t q[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    ttl_irq_request_latch #(
        .WIDTH_IN   (8),
        .WIDTH_OUT  (3),
        .DELAY_RISE (0),
        .DELAY_FALL (0)
    ) dut (
        .Clk          (Clk),
        .Clear        (Clear),
        .IR_bar       (IR_bar),
        .Mask_load    (Mask_load),
        .Mask_data    (Mask_data),
        .Ack          (Ack),
        .Ack_code_bar (Ack_code_bar),
        .Req_bar      (req_bar),
        .Int          (irq),
        .Mask         (mask),
        .Overrun      (overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) edges++;

    // Monitor: compares the entry due for the edge just taken.
    initial begin
        forever begin
            @(negedge Clk);
            while (q.size() > 0 && q[0].due <= edges) begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (e.due != edges) begin
                    errors++;
                    $display("FAIL %s: checked at edge %0d, required edge %0d", e.nm, edges, e.due);
                end else if (req_bar !== e.rb || irq !== e.irq || mask !== e.m || overrun !== e.ov) begin
                    errors++;
                    $display("FAIL %s: got Req_bar=%h Int=%b Mask=%h Overrun=%h, required Req_bar=%h Int=%b Mask=%h Overrun=%h",
                             e.nm, req_bar, irq, mask, overrun, e.rb, e.irq, e.m, e.ov);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] rb, input logic i,
                              input logic [7:0] m, input logic [7:0] ov);
        exp_t e;
        e.nm  = nm;
        e.due = edges;
        e.rb  = rb;
        e.irq = i;
        e.m   = m;
        e.ov  = ov;
        q.push_back(e);
    endtask

    // One-cycle low pulse on the given lines, then two idle edges: pending set at the third edge.
    task automatic pulse(input logic [7:0] lines_bar);
        IR_bar = lines_bar;
        tick();
        IR_bar = 8'hFF;
        tick();
        tick();
    endtask

    task automatic ack_line(input logic [2:0] code_bar);
        Ack          = 1'b1;
        Ack_code_bar = code_bar;
        tick();
        Ack          = 1'b0;
        Ack_code_bar = 3'b111;
    endtask

    task automatic load_mask(input logic [7:0] d);
        Mask_load = 1'b1;
        Mask_data = d;
        tick();
        Mask_load = 1'b0;
    endtask

    initial begin
        Clear        = 1'b1;
        IR_bar       = 8'hFF;
        Mask_load    = 1'b0;
        Mask_data    = 8'h00;
        Ack          = 1'b0;
        Ack_code_bar = 3'b111;

        // Reset and idle
        tick();
        Clear = 1'b0;
        expect_out("reset", 8'hFF, 1'b0, 8'h00, 8'h00);
        tick();
        expect_out("idle", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Line 2 latency and ack
        IR_bar = 8'hFB;
        tick();
        tick();
        expect_out("lat_edge2", 8'hFF, 1'b0, 8'h00, 8'h00);
        tick();
        expect_out("lat_edge3", 8'hFB, 1'b1, 8'h00, 8'h00);
        IR_bar = 8'hFF;
        ack_line(3'b101);
        expect_out("ack_line2", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Lines 7 and 2 together, ack in encoder priority order
        pulse(8'h7B);
        expect_out("pair_set", 8'h7B, 1'b1, 8'h00, 8'h00);
        ack_line(3'b000);
        expect_out("pair_ack7", 8'hFB, 1'b1, 8'h00, 8'h00);
        ack_line(3'b010);
        expect_out("ack_nonpending", 8'hFB, 1'b1, 8'h00, 8'h00);
        ack_line(3'b101);
        expect_out("pair_ack2", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Mask hides but still captures
        load_mask(8'h80);
        expect_out("mask_load", 8'hFF, 1'b0, 8'h80, 8'h00);
        pulse(8'h7F);
        expect_out("masked_pulse", 8'hFF, 1'b0, 8'h80, 8'h00);
        load_mask(8'h00);
        expect_out("unmask", 8'h7F, 1'b1, 8'h00, 8'h00);
        Mask_load    = 1'b1;
        Mask_data    = 8'h01;
        Ack          = 1'b1;
        Ack_code_bar = 3'b000;
        tick();
        Mask_load    = 1'b0;
        Ack          = 1'b0;
        Ack_code_bar = 3'b111;
        expect_out("ack_with_mask", 8'hFF, 1'b0, 8'h01, 8'h00);
        load_mask(8'h00);
        expect_out("mask_clear", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Overrun on line 0
        pulse(8'hFE);
        expect_out("ovr_first", 8'hFE, 1'b1, 8'h00, 8'h00);
        pulse(8'hFE);
        expect_out("ovr_second", 8'hFE, 1'b1, 8'h00, 8'h01);
        ack_line(3'b111);
        expect_out("ovr_sticky", 8'hFF, 1'b0, 8'h00, 8'h01);
        Clear = 1'b1;
        tick();
        Clear = 1'b0;
        expect_out("ovr_cleared", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Edge coincident with ack of the same line
        pulse(8'hFE);
        expect_out("coinc_first", 8'hFE, 1'b1, 8'h00, 8'h00);
        IR_bar = 8'hFE;
        tick();
        IR_bar = 8'hFF;
        tick();
        ack_line(3'b111);
        expect_out("coinc_set_wins", 8'hFE, 1'b1, 8'h00, 8'h00);
        ack_line(3'b111);
        expect_out("coinc_retire", 8'hFF, 1'b0, 8'h00, 8'h00);

        // Level held across Clear, with Clear overriding mask load
        IR_bar = 8'hF7;
        tick();
        tick();
        tick();
        expect_out("hold_set", 8'hF7, 1'b1, 8'h00, 8'h00);
        load_mask(8'h20);
        expect_out("hold_mask", 8'hF7, 1'b1, 8'h20, 8'h00);
        Clear     = 1'b1;
        Mask_load = 1'b1;
        Mask_data = 8'hFF;
        tick();
        Clear     = 1'b0;
        Mask_load = 1'b0;
        expect_out("hold_clear", 8'hFF, 1'b0, 8'h00, 8'h00);
        tick();
        expect_out("hold_a1", 8'hFF, 1'b0, 8'h00, 8'h00);
        tick();
        expect_out("hold_a2", 8'hFF, 1'b0, 8'h00, 8'h00);
        tick();
        expect_out("hold_a3", 8'hF7, 1'b1, 8'h00, 8'h00);
        IR_bar = 8'hFF;

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            tick();
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d entries left, required 0", q.size());
            errors += q.size();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
